// File: rtl/arashi_mem_rd.sv
// Multi-thread read port for the arashi thread-shared memory.
// Round-robin arbitration onto one synchronous read port, two-cycle return to the requesting lane.
module arashi_mem_rd #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_WIDTH  = 8,
  parameter int unsigned THREAD_NUM = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [THREAD_NUM-1:0]            rd_req,
  input  logic [MEM_WIDTH*THREAD_NUM-1:0]  raddr,
  output logic [THREAD_NUM-1:0]            rd_gnt,
  output logic [THREAD_NUM-1:0]            rd_valid,
  output logic [DATA_WIDTH*THREAD_NUM-1:0] rdata,
  output logic                             mem_re,
  output logic [MEM_WIDTH-1:0]             mem_raddr,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  output logic                             busy
);

  localparam int unsigned PW = (THREAD_NUM > 1) ? $clog2(THREAD_NUM) : 1;

  logic [PW-1:0]                    ptr_q, ptr_d;
  logic [THREAD_NUM-1:0]            gnt_d;
  logic [THREAD_NUM-1:0]            tag_q;
  logic [THREAD_NUM-1:0]            valid_q;
  logic [DATA_WIDTH*THREAD_NUM-1:0] rdata_q;
  logic                             found;
  int unsigned                      scan_idx;

  // Scan p, p+1, ... wrapping; first requester wins and the pointer moves past it.
  always_comb begin
    gnt_d     = '0;
    ptr_d     = ptr_q;
    mem_raddr = '0;
    found     = 1'b0;
    scan_idx  = 0;
    if (!rst) begin
      for (int unsigned i = 0; i < THREAD_NUM; i++) begin
        scan_idx = (32'(ptr_q) + i) % THREAD_NUM;
        if (!found && rd_req[scan_idx]) begin
          found           = 1'b1;
          gnt_d[scan_idx] = 1'b1;
          mem_raddr       = raddr[scan_idx*MEM_WIDTH +: MEM_WIDTH];
          ptr_d           = (scan_idx + 1 == THREAD_NUM) ? '0 : PW'(scan_idx + 1);
        end
      end
    end
  end

  assign rd_gnt = gnt_d;
  assign mem_re = |gnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      tag_q   <= '0;
      valid_q <= '0;
      rdata_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      tag_q   <= gnt_d;
      valid_q <= tag_q;
      for (int unsigned t = 0; t < THREAD_NUM; t++) begin
        if (tag_q[t]) rdata_q[t*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
      end
    end
  end

  assign rd_valid = valid_q;
  assign rdata    = rdata_q;
  assign busy     = (|tag_q) | (|valid_q);

endmodule

// File: tb/tb_arashi_mem_rd.sv
// Directed and random checks of arashi_mem_rd against a grant-order return-queue model.
module tb_arashi_mem_rd;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   rd_req;
  logic [31:0]  raddr;
  logic [3:0]   rd_gnt;
  logic [3:0]   rd_valid;
  logic [127:0] rdata;
  logic         mem_re;
  logic [7:0]   mem_raddr;
  logic [31:0]  mem_rdata;
  logic         busy;

  int total = 0;
  int bad   = 0;

  arashi_mem_rd #(.DATA_WIDTH(32), .MEM_WIDTH(8), .THREAD_NUM(4)) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .raddr(raddr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rdata(rdata), .mem_re(mem_re), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous memory: mem[a] = a + 0x100; garbage when not enabled.
  always @(posedge clk) mem_rdata <= mem_re ? ({24'h0, mem_raddr} + 32'h100) : 32'hDEAD_BEEF;

  typedef struct { int th; logic [31:0] data; int gc; } ent_t;
  ent_t         q[$];
  int           ptr = 0;
  int           cyc = 0;
  logic [127:0] exp_rd = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] req, input logic [31:0] addrs, output int g);
    logic [3:0]  eg;
    logic [7:0]  ea;
    logic [3:0]  ev;
    logic        eb;
    logic [31:0] a;
    rst = r; rd_req = req; raddr = addrs;
    #1;
    g = -1; eg = '0; ea = '0; ev = '0; eb = 1'b0;
    if (!r) begin
      for (int i = 0; i < 4; i++) begin
        int t;
        t = (ptr + i) % 4;
        if (g < 0 && req[t]) g = t;
      end
    end
    if (g >= 0) begin
      eg[g] = 1'b1;
      ea = addrs[g*8 +: 8];
    end
    foreach (q[k]) begin
      if (q[k].gc == cyc - 2) begin
        ev[q[k].th] = 1'b1;
        exp_rd[q[k].th*32 +: 32] = q[k].data;
      end
      if (q[k].gc == cyc - 1 || q[k].gc == cyc - 2) eb = 1'b1;
    end
    check("rd_gnt",    128'(rd_gnt),    128'(eg));
    check("mem_re",    128'(mem_re),    128'(g >= 0));
    check("mem_raddr", 128'(mem_raddr), 128'(ea));
    check("rd_valid",  128'(rd_valid),  128'(ev));
    check("busy",      128'(busy),      128'(eb));
    check("rdata",     rdata,           exp_rd);
    @(posedge clk);
    if (r) begin
      q.delete();
      ptr = 0;
      exp_rd = '0;
    end else if (g >= 0) begin
      a = {24'h0, ea} + 32'h100;
      q.push_back('{th: g, data: a, gc: cyc});
      ptr = (g + 1) % 4;
    end
    while (q.size() > 0 && q[0].gc < cyc - 1) void'(q.pop_front());
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int g;
    logic [3:0]  pend;
    logic [31:0] paddr;
    rst = 1'b1; rd_req = '0; raddr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state and idle lead-in; then single read from thread 2.
    repeat (9) step(1'b0, 4'b0000, 32'h0, g);
    step(1'b0, 4'b0100, 32'h0005_0000, g);
    repeat (3) step(1'b0, 4'b0000, 32'h0, g);

    // All four requesting continuously.
    repeat (6) step(1'b0, 4'b1111, 32'h3322_1100, g);
    repeat (2) step(1'b0, 4'b0000, 32'h0, g);

    // Fairness: thread 3 granted, then 0 and 3 together.
    step(1'b0, 4'b1000, 32'h4400_0000, g);
    step(1'b0, 4'b1001, 32'h4400_0040, g);
    step(1'b0, 4'b1000, 32'h4400_0000, g);
    repeat (2) step(1'b0, 4'b0000, 32'h0, g);

    // Lone streaming requester across the address wrap.
    step(1'b0, 4'b0010, 32'h0000_FE00, g);
    step(1'b0, 4'b0010, 32'h0000_FF00, g);
    step(1'b0, 4'b0010, 32'h0000_0000, g);
    repeat (3) step(1'b0, 4'b0000, 32'h0, g);

    // Reset mid-flight, then threads 1 and 3 together.
    step(1'b0, 4'b0100, 32'h0077_0000, g);
    step(1'b1, 4'b0000, 32'h0, g);
    step(1'b0, 4'b1010, 32'h5500_6600, g);
    step(1'b0, 4'b1000, 32'h5500_0000, g);
    repeat (3) step(1'b0, 4'b0000, 32'h0, g);

    // Preload lanes so the idle hold is visible, then idle.
    repeat (4) step(1'b0, 4'b1111, 32'hA1B2_C3D4, g);
    repeat (20) step(1'b0, 4'b0000, 32'h0, g);

    // Random traffic honouring hold-until-granted, with occasional reset.
    pend = '0; paddr = '0;
    for (int n = 0; n < 400; n++) begin
      logic r;
      for (int t = 0; t < 4; t++) begin
        if (!pend[t] && $urandom_range(0, 2) != 0) begin
          pend[t] = 1'b1;
          paddr[t*8 +: 8] = 8'($urandom);
        end
      end
      r = ($urandom_range(0, 59) == 0);
      step(r, pend, paddr, g);
      if (g >= 0) pend[g] = 1'b0;
    end
    repeat (3) step(1'b0, 4'b0000, 32'h0, g);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
